// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the control FSM and the 64-bit doubleword data memory.
// Sub-doubleword stores use read-modify-write; loads extract and extend a byte lane.
module mem_access_ctrl #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  func3,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [63:0] load_data,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_wr,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;

    logic        is_store_q;
    logic [2:0]  func3_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] merged_q;
    logic        err_q;
    logic [63:0] load_data_q;
    logic        req_err;
    logic        req_sd;

    // Illegal func3 for the direction, or offset not aligned to the access size.
    function automatic logic access_err(input logic st, input logic [2:0] f3,
                                        input logic [2:0] off);
        logic illegal;
        logic misal;
        illegal = st ? f3[2] : (f3 == 3'b111);
        case (f3[1:0])
            2'b01:   misal = off[0];
            2'b10:   misal = |off[1:0];
            2'b11:   misal = |off;
            default: misal = 1'b0;
        endcase
        return illegal | misal;
    endfunction

    function automatic logic [63:0] load_extend(input logic [63:0] rdata,
                                                input logic [2:0] f3,
                                                input logic [2:0] off);
        logic        [63:0] lane;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        logic        [63:0] res;
        lane = rdata >> {off, 3'b000};
        b    = lane[7:0];
        h    = lane[15:0];
        w    = lane[31:0];
        case (f3)
            3'b000:  res = {{56{b[7]}}, b};
            3'b001:  res = {{48{h[15]}}, h};
            3'b010:  res = {{32{w[31]}}, w};
            3'b100:  res = {56'd0, lane[7:0]};
            3'b101:  res = {48'd0, lane[15:0]};
            3'b110:  res = {32'd0, lane[31:0]};
            default: res = lane;
        endcase
        return res;
    endfunction

    function automatic logic [63:0] merge_store(input logic [63:0] rdata,
                                                input logic [63:0] wd,
                                                input logic [2:0] f3,
                                                input logic [2:0] off);
        logic [63:0] mask;
        logic [5:0]  sh;
        case (f3[1:0])
            2'b00:   mask = 64'h0000_0000_0000_00FF;
            2'b01:   mask = 64'h0000_0000_0000_FFFF;
            2'b10:   mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        sh = {off, 3'b000};
        return (rdata & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    assign req_err = access_err(is_store, func3, addr[2:0]);
    assign req_sd  = is_store && (func3 == 3'b011);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 64'd0;
        mem_wdata = 64'd0;
        if (state != IDLE) begin
            busy     = 1'b1;
            mem_addr = {addr_q[63:3], 3'b000};
        end
        case (state)
            IDLE: begin
                if (start) begin
                    if (req_err) begin
                        state_nxt = DONE;
                    end else if (req_sd) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            RD: begin
                if (cnt == 3'd0) begin
                    state_nxt = CAP;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            CAP: begin
                state_nxt = is_store_q ? WR : DONE;
            end
            WR: begin
                mem_wr    = 1'b1;
                mem_wdata = merged_q;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                err       = err_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch; for sd the raw store data is the write data, otherwise CAP merges.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            is_store_q <= is_store;
            func3_q    <= func3;
            addr_q     <= addr;
            wdata_q    <= wdata;
            err_q      <= req_err;
            merged_q   <= wdata;
        end else if (state == CAP && is_store_q) begin
            merged_q   <= merge_store(mem_rdata, wdata_q, func3_q, addr_q[2:0]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_data_q <= 64'd0;
        end else if (state == CAP && !is_store_q) begin
            load_data_q <= load_extend(mem_rdata, func3_q, addr_q[2:0]);
        end
    end

    assign load_data = load_data_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Multi-cycle load/store sequencer between the main control FSM and the 64-bit doubleword data memory. It takes one memory request per start pulse and runs it to completion:
- loads: lb/lh/lw/ld/lbu/lhu/lwu, with byte-lane extraction and sign/zero extension;
- stores: sb/sh/sw/sd, with read-modify-write for sub-doubleword sizes.

The control FSM waits on done before issuing register write-back or the next fetch.

Parameters:
MEM_LAT, 1, memory read latency in cycles; legal 1..7; mem_rdata is valid in the cycle after the last read-address cycle.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  request strobe; sampled only in IDLE
is_store  in  1  1=store, 0=load; latched with start
func3  in  3  access size/sign (RISC-V encoding); latched with start
addr  in  64  byte address; latched with start
wdata  in  64  store data (rs2); latched with start
busy  out  1  high in every non-IDLE state
done  out  1  one-cycle completion pulse
err  out  1  valid with done; misaligned or illegal func3
load_data  out  64  extended load result; updated in CAP, held until next load completes
mem_addr  out  64  {addr_q[63:3],3'b000} in non-IDLE states, 0 in IDLE
mem_wdata  out  64  merged store data in WR, 0 otherwise
mem_wr  out  1  memory write enable; high only in WR
mem_rdata  in  64  memory read data

Behaviour:
- Reset (async): state=IDLE; busy, done, err, mem_wr=0; load_data, mem_wdata, mem_addr=0; latency counter=0. Reset during WR drops mem_wr immediately; no partial write is retried.
- Little-endian lanes: byte k is bits [8k+7:8k]; off = addr_q[2:0].
- Legal load func3: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu. func3 111 is illegal.
- Legal store func3: 000 sb, 001 sh, 010 sw, 011 sd. 1xx is illegal.
- Alignment: h needs off[0]=0; w needs off[1:0]=0; d needs off=0. Violation or illegal func3 sets err.

States:
- IDLE: on start, latch the inputs.
  - err condition -> DONE with err=1.
  - sd -> WR.
  - all others -> RD with counter=MEM_LAT-1.
- RD: mem_wr=0, address driven. Counter decrements each cycle; at 0 -> CAP. RD lasts exactly MEM_LAT cycles.
- CAP: mem_rdata sampled.
  - Load: load_data = selected lane shifted right by 8*off, then sign-extended (lb/lh/lw) or zero-extended (lbu/lhu/lwu/ld) -> DONE.
  - Store: merged = mem_rdata with lane(s) at off replaced by wdata_q low byte/half/word; register it -> WR.
- WR: mem_wr=1 for exactly one cycle. mem_wdata = merged data, or wdata_q for sd -> DONE.
- DONE: done=1, err as decided -> IDLE. err is 0 whenever done=1 for a good access.

Rules:
- Latency counted from the start cycle to the done cycle: load MEM_LAT+2; sub-word store MEM_LAT+3; sd 2; error 1.
- start is ignored in any non-IDLE state, including DONE; the requester must re-present it.
- A store never updates load_data. An errored access performs no memory read or write and leaves load_data unchanged.
- No memory write ever occurs outside WR. mem_wr is never high in two consecutive cycles.

Test Plan:
1. MEM_LAT=1, mem[0x10]=0x8877665544332211. lb 0x17 -> load_data=0xFFFFFFFFFFFFFF88, done in cycle 3. lbu 0x17 -> 0x88. lh 0x16 -> 0xFFFFFFFFFFFF8877. lwu 0x14 -> 0x0000000088776655. ld 0x10 -> 0x8877665544332211. err=0 throughout.
2. sb addr 0x11, wdata=0xAB -> one read, then a single mem_wr cycle in cycle 3 with mem_wdata=0x887766554433AB11; done in cycle 4. sw 0x14, wdata=0xDEADBEEF -> mem_wdata=0xDEADBEEF44332211.
3. sd addr 0x18, wdata=0x0123456789ABCDEF -> mem_wr in cycle 1 with no RD state, done in cycle 2, mem_addr=0x18.
4. lw addr 0x12 and sh addr 0x13 -> done+err in cycle 1, mem_wr never asserted, load_data unchanged. Load func3=111 -> err.
5. Re-run scenario 1 with MEM_LAT=3 -> lb done in cycle 5. Pulse start again while busy and during DONE -> ignored; exactly one done per accepted start.
6. Assert reset during the WR cycle of an sb -> mem_wr falls in the same cycle, busy=0, state=IDLE. A new lb after release completes normally.
